// File: rtl/nfc_cmd_arbiter.sv
// Round-robin arbiter sharing one NAND controller command port among NREQ requesters.
// Optional WAIT watchdog and tmo output enabled by defining NFC_ARB_TIMEOUT_EN.
module nfc_cmd_arbiter #(
    parameter int NREQ    = 2,
    parameter int ADDR_W  = 16,
    parameter int TMO_CYC = 65535
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req,
    input  logic [3*NREQ-1:0]      req_cmd,
    input  logic [ADDR_W*NREQ-1:0] req_addr,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        rsp_done,
    output logic                   rsp_err,
    output logic                   busy,
    output logic [2:0]             nfc_cmd,
    output logic                   nfc_strt,
    output logic [ADDR_W-1:0]      RWA,
    input  logic                   nfc_done,
    input  logic                   Perr,
    input  logic                   EErr,
    input  logic                   RErr
`ifdef NFC_ARB_TIMEOUT_EN
    ,
    output logic                   tmo
`endif
);

    localparam int PW = (NREQ > 2) ? 2 : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_GRANT = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [PW-1:0]     rr_q, rr_d;
    logic [PW-1:0]     win_q, win_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic              err_q, err_d;
    logic              strt_q, strt_d;
    logic [2:0]        cmd_q, cmd_d;
    logic [ADDR_W-1:0] rwa_q, rwa_d;
    logic              tmo_q, tmo_d;
    logic [15:0]       cnt_q, cnt_d;

    logic [NREQ-1:0]   req_hi;
    logic [NREQ-1:0]   pick_oh;
    logic [PW-1:0]     pick;
    logic [2:0]        sel_cmd;
    logic [ADDR_W-1:0] sel_addr;
    logic              cmd_ok;
    logic              err_sel;

    // Requests at or above the pointer win first; otherwise wrap to the lowest.
    always_comb begin
        req_hi   = '0;
        pick     = '0;
        pick_oh  = '0;
        sel_cmd  = '0;
        sel_addr = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_hi[i] = req[i] && (PW'(i) >= rr_q);
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) pick = PW'(i);
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_hi[i]) pick = PW'(i);
        end
        for (int i = 0; i < NREQ; i++) begin
            if (PW'(i) == pick) begin
                pick_oh[i] = 1'b1;
                sel_cmd    = req_cmd[3*i +: 3];
                sel_addr   = req_addr[ADDR_W*i +: ADDR_W];
            end
        end
    end

    always_comb begin
        cmd_ok  = 1'b0;
        err_sel = 1'b0;
        case (cmd_q)
            3'b001:  begin cmd_ok = 1'b1; err_sel = Perr; end
            3'b010:  begin cmd_ok = 1'b1; err_sel = RErr; end
            3'b100:  begin cmd_ok = 1'b1; err_sel = EErr; end
            3'b011:  cmd_ok = 1'b1;
            3'b101:  cmd_ok = 1'b1;
            default: cmd_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        win_d   = win_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        err_d   = 1'b0;
        strt_d  = 1'b0;
        cmd_d   = cmd_q;
        rwa_d   = rwa_q;
        tmo_d   = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    win_d   = pick;
                    gnt_d   = pick_oh;
                    cmd_d   = sel_cmd;
                    rwa_d   = sel_addr;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                if (!cmd_ok) begin
                    done_d  = gnt_q;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    strt_d  = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 16'd1;
                if (nfc_done) begin
                    done_d  = gnt_q;
                    err_d   = err_sel;
                    state_d = S_RESP;
                end
`ifdef NFC_ARB_TIMEOUT_EN
                else if (cnt_q == 16'(TMO_CYC - 1)) begin
                    done_d  = gnt_q;
                    err_d   = 1'b1;
                    tmo_d   = 1'b1;
                    state_d = S_RESP;
                end
`endif
            end
            S_RESP: begin
                gnt_d   = '0;
                rr_d    = (win_q == PW'(NREQ - 1)) ? '0 : win_q + PW'(1);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            win_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            strt_q  <= 1'b0;
            cmd_q   <= '0;
            rwa_q   <= '0;
            tmo_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            win_q   <= win_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            strt_q  <= strt_d;
            cmd_q   <= cmd_d;
            rwa_q   <= rwa_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt      = gnt_q;
    assign rsp_done = done_q;
    assign rsp_err  = err_q;
    assign busy     = (state_q != S_IDLE);
    assign nfc_cmd  = cmd_q;
    assign nfc_strt = strt_q;
    assign RWA      = rwa_q;
`ifdef NFC_ARB_TIMEOUT_EN
    assign tmo      = tmo_q;
`else
    logic unused_tmo;
    assign unused_tmo = tmo_q ^ (|cnt_q);
`endif

endmodule

// File: tb/tb_nfc_cmd_arbiter.sv
// Randomized transaction-level bench for nfc_cmd_arbiter (NREQ=2, ADDR_W=16).
// Reference model: round-robin pointer plus per-command error rules.
module tb_nfc_cmd_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [5:0]  req_cmd;
    logic [31:0] req_addr;
    logic [1:0]  gnt, rsp_done;
    logic        rsp_err, busy, nfc_strt;
    logic [2:0]  nfc_cmd;
    logic [15:0] RWA;
    logic        nfc_done, Perr, EErr, RErr;
`ifdef NFC_ARB_TIMEOUT_EN
    logic        tmo;
`endif

    int vectors = 0;
    int miscompares = 0;
    int rr_m = 0;

    always #5 clk = ~clk;

    nfc_cmd_arbiter #(.NREQ(2), .ADDR_W(16), .TMO_CYC(100)) dut (
        .clk(clk), .reset(reset), .req(req), .req_cmd(req_cmd),
        .req_addr(req_addr), .gnt(gnt), .rsp_done(rsp_done),
        .rsp_err(rsp_err), .busy(busy), .nfc_cmd(nfc_cmd),
        .nfc_strt(nfc_strt), .RWA(RWA), .nfc_done(nfc_done),
`ifdef NFC_ARB_TIMEOUT_EN
        .tmo(tmo),
`endif
        .Perr(Perr), .EErr(EErr), .RErr(RErr)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic int model_winner(input logic [1:0] rv);
        int idx;
        for (int k = 0; k < 2; k++) begin
            idx = (rr_m + k) % 2;
            if (rv[idx]) return idx;
        end
        return 0;
    endfunction

    // fl = {Perr, EErr, RErr}
    function automatic logic model_err(input logic [2:0] c, input logic [2:0] fl);
        if (c == 3'b001) return fl[2];
        if (c == 3'b100) return fl[1];
        if (c == 3'b010) return fl[0];
        return 1'b0;
    endfunction

    function automatic logic model_valid(input logic [2:0] c);
        return c inside {3'b001, 3'b010, 3'b100, 3'b011, 3'b101};
    endfunction

    task automatic run_txn(input logic [1:0] rv, input logic [5:0] cv,
                           input logic [31:0] av, input int dly,
                           input logic [2:0] fl, input bit hold);
        int w;
        logic [1:0]  oh;
        logic [2:0]  c;
        logic [15:0] a;
        logic        e;
        w  = model_winner(rv);
        oh = 2'b01 << w;
        c  = cv[3*w +: 3];
        a  = av[16*w +: 16];
        e  = model_err(c, fl);
        req = rv; req_cmd = cv; req_addr = av;
        step;
        vectors++;
        if ({gnt, busy, nfc_strt, rsp_done, nfc_cmd, RWA} !== {oh, 2'b10, 2'b00, c, a}) begin
            miscompares++;
            $display("FAIL grant: got gnt=%b busy=%b strt=%b done=%b cmd=%b RWA=%h exp gnt=%b cmd=%b RWA=%h",
                     gnt, busy, nfc_strt, rsp_done, nfc_cmd, RWA, oh, c, a);
        end
        nfc_done = 1'($urandom);
        step;
        if (!model_valid(c)) begin
            vectors++;
            if ({gnt, nfc_strt, rsp_done, rsp_err} !== {oh, 1'b0, oh, 1'b1}) begin
                miscompares++;
                $display("FAIL invalid_resp: got gnt=%b strt=%b done=%b err=%b exp done=%b err=1",
                         gnt, nfc_strt, rsp_done, rsp_err, oh);
            end
        end else begin
            vectors++;
            if ({gnt, nfc_strt, rsp_done, nfc_cmd, RWA} !== {oh, 1'b1, 2'b00, c, a}) begin
                miscompares++;
                $display("FAIL issue: got gnt=%b strt=%b done=%b cmd=%b RWA=%h exp strt=1 cmd=%b RWA=%h",
                         gnt, nfc_strt, rsp_done, nfc_cmd, RWA, c, a);
            end
            nfc_done = 1'($urandom);
            step;
            nfc_done = 1'b0;
            for (int j = 0; j < dly; j++) begin
                vectors++;
                if ({nfc_strt, rsp_done, busy, nfc_cmd, RWA} !== {1'b0, 2'b00, 1'b1, c, a}) begin
                    miscompares++;
                    $display("FAIL wait: got strt=%b done=%b busy=%b cmd=%b RWA=%h exp 0 00 1 %b %h",
                             nfc_strt, rsp_done, busy, nfc_cmd, RWA, c, a);
                end
                step;
            end
            nfc_done = 1'b1;
            {Perr, EErr, RErr} = fl;
            step;
            vectors++;
            if ({gnt, rsp_done, rsp_err, nfc_strt} !== {oh, oh, e, 1'b0}) begin
                miscompares++;
                $display("FAIL resp: got gnt=%b done=%b err=%b strt=%b exp gnt=%b done=%b err=%b",
                         gnt, rsp_done, rsp_err, nfc_strt, oh, oh, e);
            end
        end
        nfc_done = 1'($urandom);
        {Perr, EErr, RErr} = 3'($urandom);
        if (!hold) req[w] = 1'b0;
        step;
        vectors++;
        if ({gnt, rsp_done, busy, nfc_strt, nfc_cmd, RWA} !== {2'b00, 2'b00, 2'b00, c, a}) begin
            miscompares++;
            $display("FAIL idle: got gnt=%b done=%b busy=%b strt=%b cmd=%b RWA=%h exp idle cmd=%b RWA=%h",
                     gnt, rsp_done, busy, nfc_strt, nfc_cmd, RWA, c, a);
        end
        nfc_done = 1'b0;
        rr_m = (w + 1) % 2;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        req = '0; req_cmd = '0; req_addr = '0;
        nfc_done = 1'b0; Perr = 1'b0; EErr = 1'b0; RErr = 1'b0;
        #23;
        vectors++;
        if ({gnt, rsp_done, rsp_err, busy, nfc_strt, nfc_cmd, RWA} !== 26'd0) begin
            miscompares++;
            $display("FAIL reset_state: got gnt=%b done=%b err=%b busy=%b strt=%b cmd=%b RWA=%h exp all 0",
                     gnt, rsp_done, rsp_err, busy, nfc_strt, nfc_cmd, RWA);
        end
        @(negedge clk);
        reset = 1'b1;
        rr_m = 0;
        step;
    endtask

    task automatic test_single_read;
        run_txn(2'b01, 6'b000_010, 32'h0000_0123, 17, 3'b000, 1'b0);
    endtask

    task automatic test_fairness;
        for (int n = 0; n < 4; n++)
            run_txn(2'b11, 6'b101_011, 32'hBEEF_CAFE, n, 3'b111, 1'b1);
        req = '0;
    endtask

    task automatic test_error_map;
        run_txn(2'b01, 6'b000_100, 32'h0000_0F00, 2, 3'b010, 1'b0);
        run_txn(2'b10, 6'b001_000, 32'h1234_0000, 1, 3'b001, 1'b0);
        run_txn(2'b01, 6'b000_001, 32'h0000_0042, 0, 3'b100, 1'b0);
        run_txn(2'b10, 6'b010_000, 32'h5555_0000, 3, 3'b001, 1'b0);
    endtask

    task automatic test_invalid;
        run_txn(2'b01, 6'b000_111, 32'h0000_7777, 0, 3'b000, 1'b0);
        run_txn(2'b10, 6'b000_000, 32'hAAAA_0000, 0, 3'b000, 1'b0);
        run_txn(2'b11, 6'b110_110, 32'h1111_2222, 0, 3'b000, 1'b0);
    endtask

    task automatic test_random;
        for (int n = 0; n < 30; n++)
            run_txn(2'($urandom_range(1, 3)), 6'($urandom), $urandom,
                    int'($urandom_range(0, 5)), 3'($urandom), 1'($urandom));
        req = '0;
        step;
    endtask

`ifdef NFC_ARB_TIMEOUT_EN
    task automatic test_timeout;
        int n;
        int w;
        w = model_winner(2'b10);
        req = 2'b10; req_cmd = 6'b010_000; req_addr = 32'h0BAD_0000;
        step;
        step;
        vectors++;
        if (nfc_strt !== 1'b1) begin
            miscompares++;
            $display("FAIL tmo_strt: got strt=%b exp 1", nfc_strt);
        end
        n = 0;
        do begin
            step;
            n++;
        end while (rsp_done == 2'b00 && n < 300);
        vectors++;
        if (n != 101 || rsp_done !== (2'b01 << w) || rsp_err !== 1'b1 || tmo !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout: got cycles=%0d done=%b err=%b tmo=%b exp cycles=101 err=1 tmo=1",
                     n, rsp_done, rsp_err, tmo);
        end
        req = '0;
        nfc_done = 1'b1;
        step;
        nfc_done = 1'b1;
        step;
        nfc_done = 1'b0;
        vectors++;
        if ({rsp_done, busy, tmo} !== 4'b0000) begin
            miscompares++;
            $display("FAIL late_done: got done=%b busy=%b tmo=%b exp 0", rsp_done, busy, tmo);
        end
        rr_m = (w + 1) % 2;
        run_txn(2'b11, 6'b010_010, 32'h2222_3333, 4, 3'b001, 1'b0);
        req = '0;
        step;
    endtask
`endif

    task automatic test_reset_mid;
        req = 2'b10; req_cmd = 6'b010_000; req_addr = 32'h4321_0000;
        repeat (4) step;
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        if ({gnt, rsp_done, rsp_err, busy, nfc_strt, nfc_cmd, RWA} !== 26'd0) begin
            miscompares++;
            $display("FAIL reset_mid: got gnt=%b done=%b err=%b busy=%b strt=%b cmd=%b RWA=%h exp all 0",
                     gnt, rsp_done, rsp_err, busy, nfc_strt, nfc_cmd, RWA);
        end
        req = '0;
        nfc_done = 1'b1;
        step;
        @(negedge clk);
        reset = 1'b1;
        rr_m = 0;
        for (int n = 0; n < 3; n++) begin
            step;
            vectors++;
            if ({rsp_done, busy} !== 3'b000) begin
                miscompares++;
                $display("FAIL abort_resp: got done=%b busy=%b exp 000", rsp_done, busy);
            end
        end
        nfc_done = 1'b0;
        run_txn(2'b11, 6'b001_010, 32'h9999_8888, 1, 3'b000, 1'b0);
    endtask

    initial begin
        test_reset;
        test_single_read;
        test_fairness;
        test_error_map;
        test_invalid;
        test_random;
`ifdef NFC_ARB_TIMEOUT_EN
        test_timeout;
`endif
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
